// File: rtl/instruction_fetch_unit.sv
// Purpose : fetches sequential instruction words from a combinational memory into a 2-entry decode buffer.
// Latency : a word fetched at edge N is presented to decode right after edge N when the buffer was empty.
// Backpr. : dec_ready low lets the buffer fill to 2 entries, then fetching stalls until decode pops.
//
// Ports:
//   clk, reset            - single clock, asynchronous active-low reset
//   imem_addr/imem_rdata  - instruction memory address (current PC) and returned word
//   redirect_valid/target - taken branch/jump; flushes the buffer and reloads the PC
//   halt                  - level-sensitive fetch freeze (buffer still drains)
//   dec_valid/ready/instr/pc - decode-side handshake and head entry
//   misalign_err          - one-cycle pulse after a redirect with target[1:0] != 0
//   fetch_count           - running count of entries accepted by decode
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      head_q;
  entry_t      tail_q;
  entry_t      new_entry;
  logic [1:0]  occ_q;
  logic [31:0] pc_q;
  logic        pop;
  logic        fetch;

  assign imem_addr = pc_q;
  assign dec_valid = (occ_q != 2'd0);
  // Head fields are forced to zero when empty so stale register contents never leak.
  assign dec_instr = dec_valid ? head_q.instr : 32'd0;
  assign dec_pc    = dec_valid ? head_q.pc    : 32'd0;

  always_comb begin
    new_entry = '0;
    new_entry.pc    = pc_q;
    new_entry.instr = imem_rdata;
    pop   = dec_valid && dec_ready;
    // A full buffer can still accept a fetch when decode frees a slot on the same edge.
    fetch = !halt && !redirect_valid && ((occ_q != 2'd2) || pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      occ_q        <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      // A pop coinciding with a redirect is still a real accept by decode.
      if (pop) fetch_count <= fetch_count + 32'd1;

      if (redirect_valid) begin
        occ_q <= 2'd0;
        pc_q  <= {redirect_target[31:2], 2'b00};
      end else begin
        if (fetch) pc_q <= pc_q + 32'd4;
        case ({fetch, pop})
          2'b10: begin
            if (occ_q == 2'd0) head_q <= new_entry;
            else               tail_q <= new_entry;
            occ_q <= occ_q + 2'd1;
          end
          2'b01: begin
            head_q <= tail_q;
            occ_q  <= occ_q - 2'd1;
          end
          2'b11: begin
            // Occupancy unchanged; shift the older entry forward before appending.
            if (occ_q == 2'd2) begin
              head_q <= tail_q;
              tail_q <= new_entry;
            end else begin
              head_q <= new_entry;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: expected decode stream plus architectural state.
  ent_t        exp_q[$];
  int          m_occ;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'd0;
    if (a == 32'd4) return 32'h019806B3;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_occ = 0;
    m_pc  = 32'h0;
    m_cnt = 32'h0;
    m_mis = 1'b0;
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    bit p, f;
    p = (m_occ != 0) && dec_ready;
    if (p) m_cnt = m_cnt + 1;
    if (redirect_valid) begin
      for (int i = 0; i < m_occ - int'(p); i++) void'(exp_q.pop_back());
      m_occ = 0;
      m_pc  = redirect_target & ~32'd3;
      m_mis = (redirect_target % 4) != 0;
    end else begin
      m_mis = 1'b0;
      f = !halt && (m_occ < 2 || p);
      m_occ = m_occ - int'(p) + int'(f);
      if (f) begin
        exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dec_valid"}, {31'd0, dec_valid}, 32'd0);
    check({tag, "_dec_pc"}, dec_pc, 32'd0);
    check({tag, "_dec_instr"}, dec_instr, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
    check({tag, "_fetch_count"}, fetch_count, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
  endtask

  task automatic check_state();
    if (reset) begin
      check("imem_addr", imem_addr, m_pc);
      check("dec_valid", {31'd0, dec_valid}, {31'd0, m_occ != 0});
      check("fetch_count", fetch_count, m_cnt);
      check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      if (!dec_valid) begin
        check("idle_dec_pc", dec_pc, 32'd0);
        check("idle_dec_instr", dec_instr, 32'd0);
      end
    end else begin
      check_zero_outputs("in_reset");
    end
  endtask

  // One clock: check state, apply inputs at the falling edge, update the model.
  task automatic cyc(input logic rst, input logic rv, input logic [31:0] tgt,
                     input logic h, input logic rdy);
    @(negedge clk);
    check_state();
    reset           = rst;
    redirect_valid  = rv;
    redirect_target = tgt;
    halt            = h;
    dec_ready       = rdy;
    #1;
    if (rst) model_step();
    else     model_reset();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", dec_pc, 32'hDEAD_BEEF);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          check("pop_pc", dec_pc, e.pc);
          check("pop_instr", dec_instr, e.instr);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    halt = 1'b0; dec_ready = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("power_on");

    // Release with decode always ready: PCs 0 then 4, count reaches 2.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 1);

    // Backpressure from reset: buffer saturates at 2, PC holds at 8.
    async_reset();
    cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 1);

    // Redirect to 0x2C while the buffer holds PCs 8 and 12, with a pop on that edge.
    async_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h2C, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 1);

    // Misaligned redirect, then one with halt asserted at the same time.
    cyc(1, 1, 32'h26, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h103, 1, 1);
    cyc(1, 0, 0, 0, 0);

    // Halt with a full buffer: drain, PC frozen, then resume.
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 1, 1);
    repeat (3) cyc(1, 0, 0, 0, 1);

    // Address wrap at the top of memory, then reset mid-stream.
    cyc(1, 1, 32'hFFFF_FFFC, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 1);
    async_reset();
    cyc(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 9) == 0),
          tgt,
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) < 6));
    end
    cyc(1, 0, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
